// File: rtl/mm_systolic_sched_if.sv
// mm_systolic_sched_if: start/operand-buffer/array-edge/result-row signals of the systolic sequencer.
interface mm_systolic_sched_if #(
  parameter int N         = 4,
  parameter int BIT_WIDTH = 16,
  parameter int KW        = 7,
  parameter int RW        = (N > 1) ? $clog2(N) : 1
);
  logic                      start;
  logic [KW-1:0]             k_len;
  logic                      busy;
  logic                      done;
  logic                      op_rd_en;
  logic [KW-1:0]             op_rd_addr;
  logic [N*BIT_WIDTH-1:0]    a_rd_data;
  logic [N*BIT_WIDTH-1:0]    b_rd_data;
  logic                      array_clr_n;
  logic [N*BIT_WIDTH-1:0]    west_bus;
  logic [N*BIT_WIDTH-1:0]    north_bus;
  logic [N*N*BIT_WIDTH-1:0]  arr_result;
  logic                      res_valid;
  logic                      res_ready;
  logic [RW-1:0]             res_row_idx;
  logic [N*BIT_WIDTH-1:0]    res_data;

  modport slave (
    input  start, k_len, a_rd_data, b_rd_data, arr_result, res_ready,
    output busy, done, op_rd_en, op_rd_addr, array_clr_n, west_bus, north_bus,
           res_valid, res_row_idx, res_data
  );

  modport master (
    output start, k_len, a_rd_data, b_rd_data, arr_result, res_ready,
    input  busy, done, op_rd_en, op_rd_addr, array_clr_n, west_bus, north_bus,
           res_valid, res_row_idx, res_data
  );
endinterface

// File: rtl/mm_systolic_sched.sv
// mm_systolic_sched: clears, feeds (with diagonal skew), drains and reads out an N x N output-stationary systolic array.
module mm_systolic_sched #(
  parameter int N         = 4,
  parameter int BIT_WIDTH = 16,
  parameter int KMAX      = 64,
  parameter int KW        = 7,
  parameter int SAT_LAT   = 1
) (
  input logic              clk,
  input logic              rst_n,
  mm_systolic_sched_if.slave io
);
  localparam int BW = BIT_WIDTH;
  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_READ  = 3'd4;
  localparam logic [KW-1:0] CLR_LAST = KW'(SAT_LAT);
  localparam logic [KW-1:0] DRN_LAST = KW'(2 * N + SAT_LAT - 1);
  localparam logic [KW-1:0] K_MAX    = KW'(KMAX);
  localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);

  logic [2:0]    r_state;
  logic [KW-1:0] r_k;
  logic [KW-1:0] r_cnt;
  logic [RW-1:0] r_row;
  logic          r_done;
  logic          r_dv;
  logic          w_run;
  logic          w_cnt;
  logic          w_last;
  logic          w_xfer;

  assign w_run  = r_state == S_FEED || r_state == S_DRAIN;
  assign w_cnt  = w_run || r_state == S_CLEAR;
  assign w_last = (r_state == S_CLEAR && r_cnt == CLR_LAST) ||
                  (r_state == S_FEED  && r_cnt == r_k - 1'b1) ||
                  (r_state == S_DRAIN && r_cnt == DRN_LAST);
  assign w_xfer = r_state == S_READ && io.res_ready;

  always_ff @(posedge clk)
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_cnt   <= '0;
      r_row   <= '0;
      r_done  <= 1'b0;
      r_dv    <= 1'b0;
    end else begin
      r_done <= w_xfer && r_row == LAST_ROW;
      r_dv   <= r_state == S_FEED;
      r_cnt  <= (w_last || !w_cnt) ? '0 : r_cnt + 1'b1;
      r_row  <= !w_xfer ? r_row : (r_row == LAST_ROW) ? '0 : r_row + 1'b1;
      if (r_state == S_IDLE && io.start) r_k <= (io.k_len > K_MAX) ? K_MAX : io.k_len;
      case (r_state)
        S_IDLE:  if (io.start) r_state <= S_CLEAR;
        S_CLEAR: if (w_last) r_state <= (r_k == '0) ? S_READ : S_FEED;
        S_FEED:  if (w_last) r_state <= S_DRAIN;
        S_DRAIN: if (w_last) r_state <= S_READ;
        S_READ:  if (w_xfer && r_row == LAST_ROW) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end

  assign io.busy        = r_state != S_IDLE;
  assign io.done        = r_done;
  assign io.op_rd_en    = r_state == S_FEED;
  assign io.op_rd_addr  = (r_state == S_FEED) ? r_cnt : '0;
  assign io.array_clr_n = rst_n && r_state != S_CLEAR;
  assign io.res_valid   = r_state == S_READ;
  assign io.res_row_idx = r_row;
  assign io.res_data    = io.arr_result[r_row * N * BW +: N * BW];

  // Lane i is i+1 registers deep so row/column i sees operand k exactly i cycles after lane 0.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [BW-1:0] r_w [0:i];
    logic [BW-1:0] r_n [0:i];
    always_ff @(posedge clk)
      if (!rst_n || !w_run) begin
        r_w <= '{default: '0};
        r_n <= '{default: '0};
      end else begin
        r_w[0] <= r_dv ? io.a_rd_data[i*BW +: BW] : '0;
        r_n[0] <= r_dv ? io.b_rd_data[i*BW +: BW] : '0;
        for (int s = 1; s <= i; s++) begin
          r_w[s] <= r_w[s-1];
          r_n[s] <= r_n[s-1];
        end
      end
    assign io.west_bus[i*BW +: BW]  = r_w[i];
    assign io.north_bus[i*BW +: BW] = r_n[i];
  end
endmodule

// File: tb/tb_mm_systolic_sched.sv
// tb_mm_systolic_sched: drives the sequencer against an operand-buffer and Q8.8 PE-array model; scoreboard checks result rows.
module tb_mm_systolic_sched;
  localparam int N  = 2;
  localparam int BW = 16;
  localparam int KW = 7;
  localparam int SL = 1;

  typedef struct packed {
    logic        idx;
    logic [31:0] data;
  } row_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mm_systolic_sched_if #(.N(N), .BIT_WIDTH(BW), .KW(KW)) bus ();
  mm_systolic_sched #(.N(N), .BIT_WIDTH(BW), .KMAX(64), .KW(KW), .SAT_LAT(SL)) dut (
    .clk(clk), .rst_n(rst_n), .io(bus)
  );

  int cyc = 0, n_chk = 0, n_err = 0, n_rd = 0, n_done = 0, t0 = 0;
  logic [15:0] ma [128][N];
  logic [15:0] mb [128][N];
  logic [15:0] pw [N][N], pn [N][N], pm [N][N], ps [N][N];
  logic [15:0] win [N][N], nin [N][N];
  row_t q_row [$];
  int   q_lat [$];

  function automatic logic [15:0] qmul(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] p;
    p = $signed(a) * $signed(b);
    return p[23:8];
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.op_rd_en) n_rd <= n_rd + 1;
    if (bus.done) n_done <= n_done + 1;
  end

  // operand buffers: one-cycle read latency, A stored by column, B by row
  always @(posedge clk)
    if (bus.op_rd_en)
      for (int i = 0; i < N; i++) begin
        bus.a_rd_data[i*BW +: BW] <= ma[bus.op_rd_addr][i];
        bus.b_rd_data[i*BW +: BW] <= mb[bus.op_rd_addr][i];
      end

  always_comb
    for (int i = 0; i < N; i++) begin
      win[i][0] = bus.west_bus[i*BW +: BW];
      nin[0][i] = bus.north_bus[i*BW +: BW];
      for (int j = 1; j < N; j++) begin
        win[i][j] = pw[i][j-1];
        nin[j][i] = pn[j-1][i];
      end
    end

  always @(posedge clk)
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (!bus.array_clr_n) begin
          pw[i][j] <= '0; pn[i][j] <= '0; pm[i][j] <= '0; ps[i][j] <= '0;
        end else begin
          pw[i][j] <= win[i][j];
          pn[i][j] <= nin[i][j];
          pm[i][j] <= pm[i][j] + qmul(win[i][j], nin[i][j]);
          ps[i][j] <= pm[i][j];
        end

  always_comb begin
    bus.arr_result = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        bus.arr_result[(i*N+j)*BW +: BW] = ps[i][j];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitor: first-valid latency, row scoreboard, and stability under backpressure
  initial begin
    logic pv, hold, hidx;
    logic [31:0] hdat;
    row_t r;
    int el;
    pv = 0; hold = 0; hidx = 0; hdat = '0;
    forever begin
      @(negedge clk);
      #1;
      if (bus.res_valid && !pv) begin
        if (q_lat.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL unexpected_valid at cycle %0d", cyc);
        end else begin
          el = q_lat.pop_front();
          chk("first_valid_cycle", cyc, el);
        end
      end
      if (hold) begin
        chk("hold_valid", bus.res_valid, 1);
        chk("hold_idx", bus.res_row_idx, hidx);
        chk("hold_data", bus.res_data, hdat);
      end
      if (bus.res_valid && bus.res_ready) begin
        if (q_row.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL unexpected_row idx %0d data %0h", bus.res_row_idx, bus.res_data);
        end else begin
          r = q_row.pop_front();
          chk("row_idx", bus.res_row_idx, r.idx);
          chk("row_data", bus.res_data, r.data);
        end
      end
      pv   = bus.res_valid;
      hold = bus.res_valid && !bus.res_ready;
      hidx = bus.res_row_idx;
      hdat = bus.res_data;
    end
  end

  task automatic load(input logic [15:0] a00, a01, a10, a11, b00, b01, b10, b11);
    ma[0][0] = a00; ma[1][0] = a01; ma[0][1] = a10; ma[1][1] = a11;
    mb[0][0] = b00; mb[0][1] = b01; mb[1][0] = b10; mb[1][1] = b11;
  endtask

  task automatic go(input int k);
    bus.start = 1'b1;
    bus.k_len = KW'(k);
    t0 = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    bus.k_len = 7'd5;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic finish_run(input int rd_exp, input int rd0);
    int w;
    w = 0;
    while (!bus.done && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("done_seen", bus.done, 1);
    chk("busy_at_done", bus.busy, 0);
    chk("rd_count", n_rd - rd0, rd_exp);
    @(negedge clk);
    chk("done_one_cycle", bus.done, 0);
  endtask

  initial begin
    int rd0, d0, w;
    bus.start = 1'b0;
    bus.k_len = '0;
    bus.res_ready = 1'b1;
    for (int k = 0; k < 128; k++)
      for (int i = 0; i < N; i++) begin
        ma[k][i] = '0;
        mb[k][i] = '0;
      end
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_rd_en", bus.op_rd_en, 0);
    chk("rst_valid", bus.res_valid, 0);
    chk("rst_addr", bus.op_rd_addr, 0);
    chk("rst_row_idx", bus.res_row_idx, 0);
    chk("rst_clr_n", bus.array_clr_n, 0);
    chk("rst_west", bus.west_bus, 0);
    chk("rst_north", bus.north_bus, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_clr_n", bus.array_clr_n, 1);
    chk("idle_busy", bus.busy, 0);

    // A = I, B = [[1,2],[3,4]] in Q8.8
    load(16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0100, 16'h0200, 16'h0300, 16'h0400);
    rd0 = n_rd;
    go(2);
    q_lat.push_back(t0 + 10);
    q_row.push_back('{1'b0, 32'h0200_0100});
    q_row.push_back('{1'b1, 32'h0400_0300});
    chk("busy_after_start", bus.busy, 1);
    chk("clear_clr_n", bus.array_clr_n, 0);
    finish_run(2, rd0);

    // A = [[1,0],[1,2]]: C = [[1,2],[7,10]]; also skew timing and an ignored start
    load(16'h0100, 16'h0000, 16'h0100, 16'h0200, 16'h0100, 16'h0200, 16'h0300, 16'h0400);
    rd0 = n_rd;
    go(2);
    q_lat.push_back(t0 + 10);
    q_row.push_back('{1'b0, 32'h0200_0100});
    q_row.push_back('{1'b1, 32'h0A00_0700});
    wait_cyc(t0 + 3);
    chk("feed_rd_en", bus.op_rd_en, 1);
    chk("feed_addr0", bus.op_rd_addr, 0);
    bus.start = 1'b1;
    bus.k_len = 7'd1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("feed_addr1", bus.op_rd_addr, 1);
    wait_cyc(t0 + 5);
    chk("skew_west0", bus.west_bus[15:0], 16'h0100);
    chk("skew_north0", bus.north_bus[15:0], 16'h0100);
    chk("skew_west1_early", bus.west_bus[31:16], 16'h0000);
    chk("skew_north1_early", bus.north_bus[31:16], 16'h0000);
    @(negedge clk);
    chk("skew_west1", bus.west_bus[31:16], 16'h0100);
    chk("skew_north1", bus.north_bus[31:16], 16'h0200);
    finish_run(2, rd0);

    // k_len = 0: straight to readout of cleared array
    rd0 = n_rd;
    go(0);
    q_lat.push_back(t0 + 3);
    q_row.push_back('{1'b0, 32'h0000_0000});
    q_row.push_back('{1'b1, 32'h0000_0000});
    finish_run(0, rd0);

    // backpressure on row 0 for 5 cycles
    load(16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0100, 16'h0200, 16'h0300, 16'h0400);
    bus.res_ready = 1'b0;
    rd0 = n_rd;
    go(2);
    q_lat.push_back(t0 + 10);
    q_row.push_back('{1'b0, 32'h0200_0100});
    q_row.push_back('{1'b1, 32'h0400_0300});
    w = 0;
    while (!bus.res_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("bp_valid", bus.res_valid, 1);
    repeat (5) @(negedge clk);
    chk("bp_row_idx", bus.res_row_idx, 0);
    bus.res_ready = 1'b1;
    finish_run(2, rd0);

    // k_len above KMAX clamps to 64
    rd0 = n_rd;
    go(100);
    q_lat.push_back(t0 + 72);
    q_row.push_back('{1'b0, 32'h0200_0100});
    q_row.push_back('{1'b1, 32'h0400_0300});
    finish_run(64, rd0);

    // reset in DRAIN abandons the run; next run starts clean
    load(16'h0100, 16'h0000, 16'h0100, 16'h0200, 16'h0100, 16'h0200, 16'h0300, 16'h0400);
    d0 = n_done;
    go(2);
    wait_cyc(t0 + 6);
    chk("drain_rd_en", bus.op_rd_en, 0);
    chk("drain_busy", bus.busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_valid", bus.res_valid, 0);
    chk("mid_rst_west", bus.west_bus, 0);
    chk("mid_rst_north", bus.north_bus, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("no_done_after_rst", n_done - d0, 0);
    chk("idle_after_rst", bus.busy, 0);
    rd0 = n_rd;
    go(2);
    q_lat.push_back(t0 + 10);
    q_row.push_back('{1'b0, 32'h0200_0100});
    q_row.push_back('{1'b1, 32'h0A00_0700});
    finish_run(2, rd0);

    repeat (3) @(negedge clk);
    chk("rows_left", q_row.size(), 0);
    chk("lats_left", q_lat.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mm_systolic_sched.md
Name: mm_systolic_sched

Overview:
- Sequencer for an N x N output-stationary systolic array of fixed-point MAC PEs.
- Each PE accumulates west x north products into its `result` register and forwards its operands east/south with one register stage per hop.
- On `start` the block:
  - clears the array,
  - streams K columns of A and K rows of B from operand buffers into the west/north edges with the diagonal skew the array needs,
  - waits for the wavefront to drain,
  - hands the N result rows to a downstream consumer over a valid/ready handshake.

Parameters:
- N, 4, array dimension (rows = columns = N).
- BIT_WIDTH, 16, operand/result word width (signed two's complement fixed point).
- KMAX, 64, maximum inner dimension.
- KW, 7, width of `k_len`/address; must be at least clog2(KMAX+1).
- SAT_LAT, 1, extra register stages between the PE MAC and the PE `result` register (saturation stage).

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, synchronous active-low reset.
- start, input, 1, one-cycle request to run a block multiply.
- k_len, input, KW, inner dimension for this run; sampled only on an accepted `start`.
- busy, output, 1, high from the cycle after an accepted `start` until `done`.
- done, output, 1, one-cycle pulse after the last result row is accepted.
- op_rd_en, output, 1, read strobe shared by both operand buffers.
- op_rd_addr, output, KW, index k (0..k_len-1).
- a_rd_data, input, N*BIT_WIDTH, column k of A; slice i is A[i][k]. Valid one cycle after `op_rd_en`.
- b_rd_data, input, N*BIT_WIDTH, row k of B; slice j is B[k][j]. Valid one cycle after `op_rd_en`.
- array_clr_n, output, 1, synchronous active-low clear driven to every PE `rst_n`.
- west_bus, output, N*BIT_WIDTH, slice i drives the west input of row i.
- north_bus, output, N*BIT_WIDTH, slice j drives the north input of column j.
- arr_result, input, N*N*BIT_WIDTH, all PE results; slice (i*N+j) is C[i][j].
- res_valid, output, 1, result row available.
- res_ready, input, 1, consumer accepts row.
- res_row_idx, output, clog2(N), index of the presented row.
- res_data, output, N*BIT_WIDTH, row C[res_row_idx][*].

Behaviour:
- Reset (`rst_n` low at a clk edge, in any state):
  - state goes to IDLE.
  - busy, done, op_rd_en, res_valid = 0; op_rd_addr, res_row_idx = 0.
  - array_clr_n = 0 while reset is asserted, 1 afterwards.
  - Skew registers and west/north buses are zeroed.
  - Reset mid-run abandons the run; no `done` is produced.
- States: IDLE, CLEAR, FEED, DRAIN, READOUT.
  - IDLE: `start` is accepted only here; `start` in any other state is ignored. On accept, latch `k_len`, go to CLEAR, busy = 1.
  - CLEAR: array_clr_n = 0 for exactly 1+SAT_LAT cycles. Buses are held at 0. Then:
    - if latched k_len = 0, go to READOUT (results are all zero);
    - else go to FEED.
  - FEED: op_rd_en = 1 for k_len consecutive cycles with op_rd_addr = 0,1,...,k_len-1. Data returned one cycle later enters the skew stage. FEED lasts k_len cycles, then go to DRAIN.
  - DRAIN: op_rd_en = 0; zeros are injected at the skew inputs. A fixed counter of 1 + 2*(N-1) + 1 + SAT_LAT cycles runs (buffer latency + skew/propagation + PE result + saturation), then go to READOUT.
  - READOUT: present rows 0..N-1 in order.
    - res_data = arr_result row res_row_idx; res_valid = 1.
    - A row transfers when res_valid && res_ready; res_row_idx then increments.
    - After row N-1 transfers: done = 1 for one cycle, busy = 0, go to IDLE.
    - res_valid and res_data stay stable while res_ready = 0.
- Skew: west slice i = A[i][k] delayed i cycles relative to slice 0; north slice j = B[k][j] delayed j cycles. Implement as per-lane shift registers of depth i (resp. j) on the buffer read data. Lane 0 is registered once.
- Outside FEED/DRAIN, the skew inputs are 0 and the shift registers are flushed to 0.
- No arithmetic is done in this block; data is passed bit-exact.
- Fixed latency: `start` accepted at cycle 0 → first res_valid at cycle 1 + (1+SAT_LAT) + k_len + (2N+SAT_LAT).
- k_len > KMAX: clamp to KMAX at latch.

Test Plan:
- N=2, BIT_WIDTH=16, Q8.8. Load A = I (0x0100 diag), B = [[0x0100,0x0200],[0x0300,0x0400]], k_len=2 → rows {0x0100,0x0200}, {0x0300,0x0400}; first res_valid at the cycle count given by the formula; done pulses once.
- Check the skew: with k_len=2, west slice 1 and north slice 1 show A[1][0] and B[0][1] exactly one cycle after slice 0 shows A[0][0] and B[0][0].
- k_len=0 → CLEAR, then READOUT of all-zero rows; op_rd_en never asserted.
- Hold res_ready=0 for 5 cycles during row 0 → res_valid held, res_data and res_row_idx stable; then rows transfer in order.
- Pulse `start` during FEED with a different k_len → ignored; the original run completes unchanged.
- Assert rst_n=0 mid-DRAIN → next cycle busy=0, res_valid=0, buses=0. A new `start` then runs correctly from a clean clear.
